// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP controller state encoding (IEEE 1149.1 style codes).
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_ctrl_fsm_t;

endpackage

// File: rtl/jtag_tap_regs.sv
// TAP data path: instruction register plus IDCODE/BYPASS/USER data registers,
// with negedge-launched TDO and a one-tck USER update strobe.
module jtag_tap_regs
    import jtag_pkg::*;
#(
    parameter int unsigned           IR_WIDTH      = 4,
    parameter logic [31:0]           IDCODE_VAL    = 32'h1BEEF001,
    parameter logic [IR_WIDTH-1:0]   IDCODE_OPC    = IR_WIDTH'(4'h1),
    parameter logic [IR_WIDTH-1:0]   USER_OPC      = IR_WIDTH'(4'h3),
    parameter int unsigned           USER_DR_WIDTH = 32
) (
    input  logic                     tck,
    input  logic                     trstn,
    input  logic                     tdi,
    input  tap_ctrl_fsm_t            tap_state,
    input  logic [USER_DR_WIDTH-1:0] user_capture_data,
    output logic                     tdo,
    output logic                     tdo_en,
    output logic [IR_WIDTH-1:0]      ir_out,
    output logic [USER_DR_WIDTH-1:0] user_update_data,
    output logic                     user_update_valid
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    logic [IR_WIDTH-1:0]      ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0]      ir_out_q, ir_out_d;
    logic [31:0]              idcode_sr_q, idcode_sr_d;
    logic                     bypass_sr_q, bypass_sr_d;
    logic [USER_DR_WIDTH-1:0] user_sr_q, user_sr_d;
    logic [USER_DR_WIDTH-1:0] user_data_q, user_data_d;
    logic                     user_valid_q, user_valid_d;
    logic                     tdo_q, tdo_d;
    logic                     tdo_en_q, tdo_en_d;

    logic                     sel_idcode;
    logic                     sel_user;
    logic                     sel_bypass;
    logic                     dr_lsb;
    logic [USER_DR_WIDTH-1:0] user_shift;

    // Any opcode other than IDCODE/USER (including all-ones) selects BYPASS.
    assign sel_idcode = (ir_out_q == IDCODE_OPC);
    assign sel_user   = (ir_out_q == USER_OPC) && !sel_idcode;
    assign sel_bypass = !sel_idcode && !sel_user;

    generate
        if (USER_DR_WIDTH == 1) begin : g_user_1
            assign user_shift = tdi;
        end else begin : g_user_n
            assign user_shift = {tdi, user_sr_q[USER_DR_WIDTH-1:1]};
        end
    endgenerate

    assign dr_lsb = sel_idcode ? idcode_sr_q[0] :
                    sel_user   ? user_sr_q[0]   : bypass_sr_q;

    always_comb begin
        ir_sr_d      = ir_sr_q;
        ir_out_d     = ir_out_q;
        idcode_sr_d  = idcode_sr_q;
        bypass_sr_d  = bypass_sr_q;
        user_sr_d    = user_sr_q;
        user_data_d  = user_data_q;
        user_valid_d = 1'b0;
        case (tap_state)
            TEST_LOGIC_RESET: ir_out_d = IDCODE_OPC;
            CAPTURE_IR:       ir_sr_d  = IR_CAPTURE;
            SHIFT_IR:         ir_sr_d  = {tdi, ir_sr_q[IR_WIDTH-1:1]};
            UPDATE_IR:        ir_out_d = ir_sr_q;
            CAPTURE_DR: begin
                if (sel_idcode) idcode_sr_d = IDCODE_VAL;
                if (sel_user)   user_sr_d   = user_capture_data;
                if (sel_bypass) bypass_sr_d = 1'b0;
            end
            SHIFT_DR: begin
                if (sel_idcode) idcode_sr_d = {tdi, idcode_sr_q[31:1]};
                if (sel_user)   user_sr_d   = user_shift;
                if (sel_bypass) bypass_sr_d = tdi;
            end
            UPDATE_DR: begin
                if (sel_user) begin
                    user_data_d  = user_sr_q;
                    user_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            ir_sr_q      <= '0;
            ir_out_q     <= IDCODE_OPC;
            idcode_sr_q  <= '0;
            bypass_sr_q  <= 1'b0;
            user_sr_q    <= '0;
            user_data_q  <= '0;
            user_valid_q <= 1'b0;
        end else begin
            ir_sr_q      <= ir_sr_d;
            ir_out_q     <= ir_out_d;
            idcode_sr_q  <= idcode_sr_d;
            bypass_sr_q  <= bypass_sr_d;
            user_sr_q    <= user_sr_d;
            user_data_q  <= user_data_d;
            user_valid_q <= user_valid_d;
        end
    end

    always_comb begin
        tdo_d    = tdo_q;
        tdo_en_d = 1'b0;
        if (tap_state == SHIFT_IR) begin
            tdo_d    = ir_sr_q[0];
            tdo_en_d = 1'b1;
        end else if (tap_state == SHIFT_DR) begin
            tdo_d    = dr_lsb;
            tdo_en_d = 1'b1;
        end
    end

    // Launch on the falling edge so the host can sample at the next rising edge.
    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign tdo               = tdo_q;
    assign tdo_en            = tdo_en_q;
    assign ir_out            = ir_out_q;
    assign user_update_data  = user_data_q;
    assign user_update_valid = user_valid_q;

endmodule

// File: tb/tb_jtag_tap_regs.sv
// Directed bench for jtag_tap_regs: drives TAP states directly, checks against a
// scan-level model every cycle plus literal expectations per scan.
module tb_jtag_tap_regs;
    import jtag_pkg::*;

    logic          tck = 1'b0;
    logic          trstn;
    logic          tdi;
    tap_ctrl_fsm_t tap_state;
    logic [31:0]   user_capture_data;
    logic          tdo;
    logic          tdo_en;
    logic [3:0]    ir_out;
    logic [31:0]   user_update_data;
    logic          user_update_valid;

    jtag_tap_regs dut (
        .tck               (tck),
        .trstn             (trstn),
        .tdi               (tdi),
        .tap_state         (tap_state),
        .user_capture_data (user_capture_data),
        .tdo               (tdo),
        .tdo_en            (tdo_en),
        .ir_out            (ir_out),
        .user_update_data  (user_update_data),
        .user_update_valid (user_update_valid)
    );

    always #5 tck = ~tck;

    int n_checks = 0;
    int n_err    = 0;
    int pulses   = 0;
    bit cmp_on   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scan-level model: registers held as plain integers, DR picked by name.
    localparam int DR_IDCODE = 0, DR_BYPASS = 1, DR_USER = 2;
    logic [63:0] m_ir_sr = 0;
    logic [63:0] m_ir_out = 64'h1;
    logic [63:0] m_dr [3] = '{default: 64'h0};
    logic [63:0] m_udata = 0;
    logic        m_valid = 0;
    logic        m_tdo = 0;
    logic        m_tdo_en = 0;

    function automatic int m_sel();
        if (m_ir_out == 64'h1) return DR_IDCODE;
        if (m_ir_out == 64'h3) return DR_USER;
        return DR_BYPASS;
    endfunction

    function automatic int m_len(input int s);
        return (s == DR_BYPASS) ? 1 : 32;
    endfunction

    always @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            m_ir_sr = 0; m_ir_out = 1; m_dr = '{default: 64'h0};
            m_udata = 0; m_valid = 0; m_tdo = 0; m_tdo_en = 0;
        end else begin
            int s;
            s = m_sel();
            m_valid = 1'b0;
            case (tap_state)
                TEST_LOGIC_RESET: m_ir_out = 1;
                CAPTURE_IR:       m_ir_sr = 1;
                SHIFT_IR:         m_ir_sr = (m_ir_sr >> 1) | (64'(tdi) << 3);
                UPDATE_IR:        m_ir_out = m_ir_sr;
                CAPTURE_DR:       m_dr[s] = (s == DR_IDCODE) ? 64'h1BEEF001 :
                                            (s == DR_USER) ? 64'(user_capture_data) : 64'h0;
                SHIFT_DR:         m_dr[s] = (m_dr[s] >> 1) | (64'(tdi) << (m_len(s) - 1));
                UPDATE_DR: if (s == DR_USER) begin
                    m_udata = m_dr[DR_USER];
                    m_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always @(negedge tck) begin
        if (trstn) begin
            m_tdo_en = 1'b0;
            if (tap_state == SHIFT_IR) begin
                m_tdo = m_ir_sr[0]; m_tdo_en = 1'b1;
            end else if (tap_state == SHIFT_DR) begin
                m_tdo = m_dr[m_sel()][0]; m_tdo_en = 1'b1;
            end
        end
    end

    // Single compare process: all outputs against the model once per tck.
    always @(negedge tck) begin
        #2;
        if (cmp_on)
            check("cycle{tdo,en,valid,ir,udata}",
                  {25'h0, tdo, tdo_en, user_update_valid, ir_out, user_update_data},
                  {25'h0, m_tdo, m_tdo_en, m_valid, m_ir_out[3:0], m_udata[31:0]});
    end

    always @(negedge tck) if (user_update_valid === 1'b1) pulses++;

    // One TAP state period: state held from just after one posedge to the next.
    task automatic tick(input tap_ctrl_fsm_t st, input logic d, output logic o);
        tap_state = st;
        tdi       = d;
        @(negedge tck); #1;
        o = tdo;
        @(posedge tck); #1;
    endtask

    task automatic scan_ir(input logic [3:0] v, output logic [3:0] o);
        logic b;
        tick(RUN_TEST_IDLE, 0, b);
        tick(SELECT_DR, 0, b);
        tick(SELECT_IR, 0, b);
        tick(CAPTURE_IR, 0, b);
        for (int i = 0; i < 4; i++) begin
            tick(SHIFT_IR, v[i], b);
            o[i] = b;
        end
        tick(EXIT1_IR, 0, b);
        tick(UPDATE_IR, 0, b);
        tick(RUN_TEST_IDLE, 0, b);
    endtask

    task automatic scan_dr(input logic [63:0] v, input int n, input int pause_at,
                           output logic [63:0] o);
        logic b;
        o = '0;
        tick(RUN_TEST_IDLE, 0, b);
        tick(SELECT_DR, 0, b);
        tick(CAPTURE_DR, 0, b);
        for (int i = 0; i < n; i++) begin
            if (pause_at > 0 && i == pause_at) begin
                tick(EXIT1_DR, 0, b);
                for (int k = 0; k < 5; k++) tick(PAUSE_DR, 0, b);
                tick(EXIT2_DR, 0, b);
            end
            tick(SHIFT_DR, v[i], b);
            o[i] = b;
        end
        tick(EXIT1_DR, 0, b);
        tick(UPDATE_DR, 0, b);
        tick(RUN_TEST_IDLE, 0, b);
    endtask

    initial begin
        logic [3:0]  ir_o;
        logic [63:0] dr_o;
        logic        b;
        int          p0;

        trstn             = 1'b0;
        tdi               = 1'b0;
        tap_state         = TEST_LOGIC_RESET;
        user_capture_data = 32'h0;
        #12;
        check("reset_state", {tdo, tdo_en, user_update_valid, ir_out, user_update_data},
              {1'b0, 1'b0, 1'b0, 4'h1, 32'h0});
        @(negedge tck); #1;
        trstn = 1'b1;
        @(posedge tck); #1;
        cmp_on = 1'b1;

        scan_dr(64'h0, 32, 0, dr_o);
        check("idcode_shift", dr_o, 64'h1BEEF001);
        $display("idcode scan: tdo=%h", dr_o[31:0]);

        scan_ir(4'hF, ir_o);
        check("ir_capture_out", 64'(ir_o), 64'h1);
        check("ir_out_bypass", 64'(ir_out), 64'hF);
        $display("ir scan F: tdo=%b ir_out=%h", ir_o, ir_out);

        scan_dr(64'hD, 4, 0, dr_o);
        check("bypass_delay", dr_o, 64'hA);
        $display("bypass scan: tdo=%h", dr_o[3:0]);

        scan_ir(4'h3, ir_o);
        user_capture_data = 32'hCAFE0001;
        p0 = pulses;
        scan_dr(64'hA5A51234, 32, 0, dr_o);
        check("user_capture_out", dr_o, 64'hCAFE0001);
        check("user_update_data", 64'(user_update_data), 64'hA5A51234);
        check("user_pulse_count", 64'(pulses - p0), 64'd1);
        $display("user scan: tdo=%h upd=%h pulses=%0d", dr_o[31:0], user_update_data, pulses - p0);

        user_capture_data = 32'h12345678;
        p0 = pulses;
        scan_dr(64'h0F1E2D3C, 32, 16, dr_o);
        check("pause_capture_out", dr_o, 64'h12345678);
        check("pause_update_data", 64'(user_update_data), 64'h0F1E2D3C);
        check("pause_pulse_count", 64'(pulses - p0), 64'd1);
        $display("paused user scan: tdo=%h upd=%h", dr_o[31:0], user_update_data);

        user_capture_data = 32'h55AA0FF0;
        scan_dr(64'h0, 0, 0, dr_o);
        check("noshift_update", 64'(user_update_data), 64'h55AA0FF0);
        $display("capture-only update: upd=%h", user_update_data);

        scan_ir(4'h1, ir_o);
        scan_dr(64'h6, 36, 0, dr_o);
        check("idcode_overlong", dr_o, 64'h6_1BEEF001);
        $display("overlong idcode scan: tdo=%h", dr_o[35:0]);

        scan_ir(4'hF, ir_o);
        tick(TEST_LOGIC_RESET, 0, b);
        check("tlr_ir_out", 64'(ir_out), 64'h1);
        $display("tlr: ir_out=%h", ir_out);

        scan_ir(4'h3, ir_o);
        user_capture_data = 32'hDEADBEEF;
        tick(RUN_TEST_IDLE, 0, b);
        tick(SELECT_DR, 0, b);
        tick(CAPTURE_DR, 0, b);
        for (int i = 0; i < 10; i++) tick(SHIFT_DR, i[0], b);
        check("pre_reset_tdo_en", 64'(tdo_en), 64'h1);
        p0 = pulses;
        #3;
        trstn = 1'b0;
        #1;
        check("midscan_reset", {tdo, tdo_en, user_update_valid, ir_out, user_update_data},
              {1'b0, 1'b0, 1'b0, 4'h1, 32'h0});
        tap_state = TEST_LOGIC_RESET;
        repeat (3) @(posedge tck);
        @(negedge tck); #1;
        trstn = 1'b1;
        @(posedge tck); #1;
        tick(RUN_TEST_IDLE, 0, b);
        check("midscan_no_pulse", 64'(pulses - p0), 64'd0);
        check("post_reset_ir", 64'(ir_out), 64'h1);
        $display("midscan reset: ir_out=%h upd=%h", ir_out, user_update_data);

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
